// File: rtl/hazard_unit.sv
// Pipeline hazard controller: data-memory wait FSM, fetch-miss, branch flush and
// load-use stall arbitration, plus a saturating count of front-end stall cycles.
`timescale 1ns/1ps
module hazard_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rd,
  input  logic        exMemRead,
  input  logic        mem_branch_taken,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        dhit,
  input  logic        ihit,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  hz_state,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DWAIT = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_ihit_pend;
  logic [15:0] r_stall_cnt;
  logic        w_halted;
  logic        w_dwait;
  logic        w_fetch_ok;
  logic        w_load_use;

  assign w_halted   = (r_state == ST_HALT);
  assign w_dwait    = !w_halted && (dmemREN || dmemWEN) && !dhit;
  assign w_fetch_ok = ihit || r_ihit_pend;
  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_load_use = exMemRead && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_next_state = r_state;
    if (wb_halt || w_halted) begin
      w_next_state = ST_HALT;
    end else if (r_state == ST_RUN) begin
      w_next_state = w_dwait ? ST_DWAIT : ST_RUN;
    end else if (dhit) begin
      w_next_state = ST_RUN;
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (w_halted || w_dwait) begin
      pc_en = 1'b0;
    end else if (!w_fetch_ok) begin
      // Fetch miss: bubble into IF/ID, back end drains; a taken branch still squashes.
      ifid_en     = 1'b1;
      ifid_flush  = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      idex_flush  = mem_branch_taken;
      exmem_flush = mem_branch_taken;
    end else if (mem_branch_taken) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (w_load_use) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_RUN;
      r_ihit_pend <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_next_state;
      // Remember a fetch that completed while the data side held the pipe.
      if (w_dwait && ihit) begin
        r_ihit_pend <= 1'b1;
      end else if (pc_en) begin
        r_ihit_pend <= 1'b0;
      end
      if (!w_halted && !pc_en && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign hz_state  = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: reference model feeds a scoreboard queue,
// directed scenarios plus a random phase, saturation and halt/reset checks.
`timescale 1ns/1ps
module tb_hazard_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        exMemRead = 0, mem_branch_taken = 0, dmemREN = 0, dmemWEN = 0;
  logic        dhit = 0, ihit = 0, wb_halt = 0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  hz_state;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  m_state;
  logic        m_pend;
  logic [15:0] m_cnt;
  logic [25:0] sb_q[$];

  hazard_unit dut (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
    .exMemRead(exMemRead), .mem_branch_taken(mem_branch_taken),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dhit(dhit), .ihit(ihit),
    .wb_halt(wb_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .hz_state(hz_state), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [7:0] model_outs();
    logic halt, dw, lu;
    halt = (m_state == 2'd2);
    dw   = !halt && (dmemREN || dmemWEN) && !dhit;
    lu   = exMemRead && (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
    if (halt || dw)              return 8'b00000_000;
    else if (!(ihit || m_pend))  return {5'b01111, 1'b1, mem_branch_taken, mem_branch_taken};
    else if (mem_branch_taken)   return 8'b11111_111;
    else if (lu)                 return 8'b00111_010;
    else                         return 8'b11111_000;
  endfunction

  task automatic model_update(input logic pc);
    logic halt, dw;
    halt = (m_state == 2'd2);
    dw   = !halt && (dmemREN || dmemWEN) && !dhit;
    if (!halt && !pc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (!halt && dw && ihit) m_pend = 1'b1;
    else if (pc)             m_pend = 1'b0;
    if (wb_halt || halt)     m_state = 2'd2;
    else if (m_state == 2'd0) m_state = dw ? 2'd1 : 2'd0;
    else                      m_state = dhit ? 2'd0 : 2'd1;
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_pend  = 1'b0;
    m_cnt   = 16'd0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick(input string tag);
    logic [7:0]  e;
    logic [25:0] obs;
    e = model_outs();
    sb_q.push_back({e, m_state, m_cnt});
    #2;
    obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, hz_state, stall_cnt};
    check(tag, 32'(obs), 32'(sb_q.pop_front()));
    @(posedge CLK);
    model_update(e[7]);
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rd = 0; exMemRead = 0; mem_branch_taken = 0;
    dmemREN = 0; dmemWEN = 0; dhit = 0; ihit = 1; wb_halt = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("reset_state", 32'(hz_state), 32'd0);
    check("reset_cnt", 32'(stall_cnt), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    tick("normal");

    // Load-use on rt: one bubble, then the bubble's ex_rd clears the hazard.
    exMemRead = 1; ex_rd = 5; id_rt = 5; id_rs = 2;
    tick("load_use");
    exMemRead = 0; ex_rd = 0;
    tick("after_bubble");
    check("lu_cnt", 32'(stall_cnt), 32'd1);

    exMemRead = 1; ex_rd = 0; id_rs = 0; id_rt = 0;
    #1 check("ld_r0_pc_en", 32'(pc_en), 32'd1);
    tick("load_r0");
    clear_inputs();

    // Data miss with a fetch completing during the wait.
    dmemREN = 1; dhit = 0; ihit = 1;
    tick("dmiss_run");
    ihit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dmiss_state", 32'(hz_state), 32'd1);
      check("dmiss_pc_en", 32'(pc_en), 32'd0);
      tick("dmiss_wait");
    end
    dhit = 1;
    #1 check("dhit_pc_en", 32'(pc_en), 32'd1);
    tick("dhit");
    check("dmiss_cnt", 32'(stall_cnt), 32'd5);
    check("dhit_state", 32'(hz_state), 32'd0);

    // Hit in the request cycle: no wait.
    dmemREN = 0; dmemWEN = 1; dhit = 1; ihit = 1;
    tick("same_cycle_hit");
    check("same_cycle_state", 32'(hz_state), 32'd0);
    clear_inputs();

    // Branch during a fetch miss, then fetch returns.
    mem_branch_taken = 1; ihit = 0;
    tick("br_fetch_miss");
    mem_branch_taken = 0; ihit = 1;
    #1 check("br_refetch_pc", 32'(pc_en), 32'd1);
    tick("br_refetch");
    mem_branch_taken = 1; exMemRead = 1; ex_rd = 3; id_rs = 3;
    tick("br_over_load_use");
    clear_inputs();

    for (int i = 0; i < 400; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      exMemRead        = ($urandom_range(0, 1) == 1);
      mem_branch_taken = ($urandom_range(0, 3) == 0);
      dmemREN          = ($urandom_range(0, 3) == 0);
      dmemWEN          = ($urandom_range(0, 5) == 0);
      dhit             = ($urandom_range(0, 1) == 1);
      ihit             = ($urandom_range(0, 3) != 0);
      tick("random");
    end

    clear_inputs();
    dhit = 1;
    tick("settle");
    ihit = 0; dhit = 0;
    for (int i = 0; i < 70000; i++) tick("saturate");
    check("sat_cnt", 32'(stall_cnt), 32'hFFFF);

    clear_inputs();
    wb_halt = 1;
    tick("halt_enter");
    wb_halt = 0;
    for (int i = 0; i < 12; i++) begin
      ihit  = ($urandom_range(0, 1) == 1);
      dmemREN = ($urandom_range(0, 1) == 1);
      #1;
      check("halt_state", 32'(hz_state), 32'd2);
      check("halt_pc_en", 32'(pc_en), 32'd0);
      tick("halt_hold");
    end
    clear_inputs();

    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("async_rst_state", 32'(hz_state), 32'd0);
    check("async_rst_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    tick("post_reset");
    ihit = 0;
    tick("post_reset_miss");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
